expand_vector_alu: RTL

//  Scalar-to-vector expansion unit; the inverse of the vector reduction ALU.
//  - A start pulse latches one scalar seed, a step value and an opcode.
//  - The unit then fills the output vector one element per enabled cycle.
//  - Used to generate broadcast operands, index ramps and geometric sequences for the vector datapath.
//  - Start/enable/done handshake matches the reduction ALU.

---
 rtl/expand_vector_alu.sv | 111 +++++++++++
 1 files changed

// File: rtl/expand_vector_alu.sv
// Scalar-to-vector expansion unit: a start request latches a seed, step and opcode,
// then one output element is written per enabled cycle until the requested length is filled.
module expand_vector_alu #(
    parameter int BITS = 8,
    parameter int N    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            set,
    input  logic [BITS-1:0] in,
    input  logic [BITS-1:0] step,
    input  logic [7:0]      out_len,
    input  logic [1:0]      sel,
    output logic [BITS-1:0] out [N-1:0],
    output logic            busy,
    output logic            done,
    output logic [1:0]      state_dbg
);

    // Handshake: a request is taken on any edge with en=1 and set=1 while not busy
    // (IDLE or DONE); busy stays high for exactly len+1 enabled edges, then done holds
    // until the next accepted request or rst. Requests seen while busy are dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(N - 1);

    state_t          state;
    logic [1:0]      sel_q;
    logic [BITS-1:0] step_q;
    logic [BITS-1:0] acc;
    logic [BITS-1:0] acc_next;
    logic [7:0]      len;
    logic [7:0]      idx;
    logic [7:0]      len_clamped;

    // Element indices never exceed N-1, so oversize lengths are clamped at acceptance.
    assign len_clamped = (out_len > LAST) ? LAST : out_len;

    assign state_dbg = state;

    // All opcodes wrap modulo 2^BITS through plain BITS-wide arithmetic.
    always_comb begin
        acc_next = acc;
        case (sel_q)
            2'b00:   acc_next = acc;
            2'b01:   acc_next = acc + step_q;
            2'b10:   acc_next = acc - step_q;
            2'b11:   acc_next = acc * step_q;
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= 8'd0;
            len    <= 8'd0;
            acc    <= '0;
            sel_q  <= 2'b00;
            step_q <= '0;
            for (int i = 0; i < N; i++) begin
                out[i] <= '0;
            end
        end else if (en) begin
            case (state)
                IDLE, DONE: begin
                    if (set) begin
                        sel_q  <= sel;
                        step_q <= step;
                        len    <= len_clamped;
                        acc    <= in;
                        idx    <= 8'd0;
                        state  <= FILL;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        for (int i = 0; i < N; i++) begin
                            out[i] <= '0;
                        end
                    end
                end
                FILL: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == 8'(i)) begin
                            out[i] <= acc;
                        end
                    end
                    acc <= acc_next;
                    idx <= idx + 8'd1;
                    if (idx == len) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
